lzw_backward_string_unwind: RTL

LZW_BACKWARD_STRING_UNWIND -- requirements
Module: lzw_backward_string_unwind

---
 rtl/lzw_backward_string_unwind_if.sv | 34 +++
 rtl/lzw_backward_string_unwind.sv | 100 ++++++++++
 2 files changed

// File: rtl/lzw_backward_string_unwind_if.sv
// lzw_backward_string_unwind_if: code, dictionary, symbol-stream and status signals of the string unwinder
interface lzw_backward_string_unwind_if #(
    parameter int CODE_W  = 14,
    parameter int DATA_W  = 8,
    parameter int MAX_LEN = 32
);
    localparam int LEN_W = $clog2(MAX_LEN + 1);
    logic                     I_state_clr;
    logic [CODE_W-1:0]        I_code;
    logic                     I_code_valid;
    logic                     O_code_ready;
    logic [CODE_W-1:0]        O_dict_addr;
    logic                     O_dict_rden;
    logic [CODE_W+DATA_W:0]   I_dict_dout;
    logic [DATA_W-1:0]        O_data;
    logic                     O_data_valid;
    logic                     I_data_ready;
    logic                     O_data_last;
    logic [LEN_W-1:0]         O_str_len;
    logic                     O_str_len_wren;
    logic                     O_err_overflow;
    logic                     O_err_invalid;
    logic [31:0]              O_code_cnt;
    modport slave (
        input  I_state_clr, I_code, I_code_valid, I_dict_dout, I_data_ready,
        output O_code_ready, O_dict_addr, O_dict_rden, O_data, O_data_valid, O_data_last,
               O_str_len, O_str_len_wren, O_err_overflow, O_err_invalid, O_code_cnt
    );
    modport master (
        output I_state_clr, I_code, I_code_valid, I_dict_dout, I_data_ready,
        input  O_code_ready, O_dict_addr, O_dict_rden, O_data, O_data_valid, O_data_last,
               O_str_len, O_str_len_wren, O_err_overflow, O_err_invalid, O_code_cnt
    );
endinterface

// File: rtl/lzw_backward_string_unwind.sv
// lzw_backward_string_unwind: walks an LZW prefix chain from a code and streams the recovered symbols
module lzw_backward_string_unwind #(
    parameter int CODE_W    = 14,
    parameter int DATA_W    = 8,
    parameter int MAX_LEN   = 32,
    parameter int ORDER_FWD = 1
) (
    input logic I_sys_clk,
    input logic I_sys_rst_n,
    lzw_backward_string_unwind_if.slave bus
);
    localparam int LEN_W = $clog2(MAX_LEN + 1);
    localparam int IDX_W = MAX_LEN > 1 ? $clog2(MAX_LEN) : 1;
    typedef enum logic [1:0] {IDLE, LOOKUP, WAIT, POP} state_t;
    state_t state_q, state_d;
    logic [CODE_W-1:0] addr_q, addr_d;
    logic [LEN_W-1:0]  cnt_q, cnt_d, pos_q, pos_d, len_q, len_d;
    logic              wren_q, wren_d, ovf_q, ovf_d, inv_q, inv_d;
    logic [31:0]       code_cnt_q, code_cnt_d;
    logic [DATA_W-1:0] buf_q [MAX_LEN];
    logic              dict_vld, hit, more, accept, pop, hs, last;
    logic [CODE_W-1:0] dict_pre;
    logic [DATA_W-1:0] dict_sym;
    logic [LEN_W-1:0]  cnt_inc;
    logic [IDX_W-1:0]  rd_sel;
    assign dict_vld = bus.I_dict_dout[CODE_W+DATA_W];
    assign dict_pre = bus.I_dict_dout[CODE_W+DATA_W-1:DATA_W];
    assign dict_sym = bus.I_dict_dout[DATA_W-1:0];
    assign cnt_inc  = cnt_q + LEN_W'(1);
    assign hit      = state_q == WAIT && dict_vld;
    assign more     = dict_pre != '0 && cnt_inc < LEN_W'(MAX_LEN);
    assign accept   = state_q == IDLE && bus.I_code_valid;
    assign pop      = state_q == POP;
    assign hs       = pop && bus.I_data_ready;
    assign last     = pos_q == cnt_q - LEN_W'(1);
    assign rd_sel   = IDX_W'(ORDER_FWD != 0 ? cnt_q - LEN_W'(1) - pos_q : pos_q);
    // State register
    always_ff @(posedge I_sys_clk or negedge I_sys_rst_n)
        if (!I_sys_rst_n) state_q <= IDLE;
        else state_q <= state_d;
    // Next state: one lookup/wait pair per symbol, then drain the buffer
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = bus.I_code_valid ? LOOKUP : IDLE;
            LOOKUP:  state_d = WAIT;
            WAIT:    state_d = !dict_vld ? IDLE : more ? LOOKUP : POP;
            default: state_d = hs && last ? IDLE : POP;
        endcase
    end
    // Datapath next values; sticky errors let a fresh error win over a clear
    always_comb begin
        addr_d     = accept ? bus.I_code : hit ? dict_pre : addr_q;
        cnt_d      = accept ? '0 : hit ? cnt_inc : cnt_q;
        pos_d      = hit ? '0 : hs ? pos_q + LEN_W'(1) : pos_q;
        len_d      = hit && !more ? cnt_inc : len_q;
        wren_d     = hit && !more;
        ovf_d      = (hit && dict_pre != '0 && cnt_inc == LEN_W'(MAX_LEN)) || (ovf_q && !bus.I_state_clr);
        inv_d      = (state_q == WAIT && !dict_vld) || (inv_q && !bus.I_state_clr);
        code_cnt_d = bus.I_state_clr ? '0 : accept ? code_cnt_q + 32'd1 : code_cnt_q;
    end
    // Datapath registers
    always_ff @(posedge I_sys_clk or negedge I_sys_rst_n)
        if (!I_sys_rst_n) begin
            addr_q     <= '0;
            cnt_q      <= '0;
            pos_q      <= '0;
            len_q      <= '0;
            wren_q     <= 1'b0;
            ovf_q      <= 1'b0;
            inv_q      <= 1'b0;
            code_cnt_q <= '0;
        end else begin
            addr_q     <= addr_d;
            cnt_q      <= cnt_d;
            pos_q      <= pos_d;
            len_q      <= len_d;
            wren_q     <= wren_d;
            ovf_q      <= ovf_d;
            inv_q      <= inv_d;
            code_cnt_q <= code_cnt_d;
        end
    // Symbol buffer in walk order; only entries below cnt_q are ever read
    always_ff @(posedge I_sys_clk)
        if (hit) buf_q[IDX_W'(cnt_q)] <= dict_sym;
    // Outputs decoded from state and registers
    always_comb begin
        bus.O_code_ready   = state_q == IDLE;
        bus.O_dict_rden    = state_q == LOOKUP;
        bus.O_dict_addr    = state_q == LOOKUP ? addr_q : '0;
        bus.O_data_valid   = pop;
        bus.O_data_last    = pop && last;
        bus.O_data         = pop ? buf_q[rd_sel] : '0;
        bus.O_str_len      = len_q;
        bus.O_str_len_wren = wren_q;
        bus.O_err_overflow = ovf_q;
        bus.O_err_invalid  = inv_q;
        bus.O_code_cnt     = code_cnt_q;
    end
endmodule
